shreg_seq: RTL and testbench
============================

Name: shreg_seq

Overview:
- Command sequencer sitting directly upstream of the lab-6 8-bit universal shift register (z61).
- Accepts one command at a time over a valid/ready handshake: load, shift left, shift right, rotate.
- Drives the register's l, r, d and i inputs cycle by cycle with a down-counter, and signals completion with a done pulse.
- Reads the register's q back only to supply the rotate bit.

Parameters:
- W, 8, register width; must match the downstream shift register.
- CW, $clog2(W)+1, width of the internal shift counter.

Ports:
- clk  in  1  clock; rising edge, the same clock that drives the register's c input
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  operation: 00 LOAD, 01 SHL, 10 SHR, 11 ROT
- cmd_arg  in  W  LOAD: data; SHL/SHR: [3:0] count, [7] fill bit; ROT: [3:0] count, [4] direction (0 left, 1 right)
- q  in  W  current register contents, fed back
- l  out  1  to register l
- r  out  1  to register r
- d  out  W  to register d
- i  out  1  to register serial input i
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Register control encoding, fixed by the downstream block:
  - l=0, r=0: hold.
  - l=0, r=1: shift left; bit0 takes i, bits move toward the MSB.
  - l=1, r=0: shift right; bit7 takes i.
  - l=1, r=1: parallel load of d.
- Reset (asynchronous, any time): state IDLE, l=0, r=0, d=0, busy=0, done=0, count=0, latched fields cleared. The register contents are not reset and keep their value.
- FSM states: IDLE, EXEC, DONE. Encoding lives in the package.
- IDLE:
  - cmd_ready=1, l=r=0, busy=0.
  - A handshake (cmd_valid & cmd_ready) at edge k latches op, count, fill/dir and data.
  - Count field 0 with a non-LOAD op: go to DONE with no register activity.
  - Count 9..15: clamp to W.
  - LOAD: count is forced to 1.
  - Otherwise go to EXEC.
- EXEC:
  - cmd_ready=0, busy=1. l/r follow the encoding for the latched op; ROT uses SHL or SHR encoding according to dir.
  - Count decrements on every edge; the register performs one operation per edge, at edges k+1 .. k+n.
  - Leave for DONE on the edge where count==1.
- DONE:
  - Exactly one cycle: done=1, busy=0, l=r=0, cmd_ready=0. Then IDLE.
  - Latency for a count-n command: done asserted in cycle k+n+1 (cycle k+1 for count 0); cmd_ready returns in cycle k+n+2.
- d is registered. It is updated only by LOAD acceptance and holds its value otherwise.
- i selection:
  - SHL/SHR: the latched fill bit.
  - ROT left: combinational q[W-1].
  - ROT right: combinational q[0].
  - Valid with the same-cycle q, so the rotate wraps correctly.
  - 0 in IDLE/DONE.
- l, r, busy, done, cmd_ready are decoded from registered state only (Moore). i is the sole output with a combinational path from an input (q).
- cmd_valid while cmd_ready=0 is ignored. No queueing, and cmd_arg is not sampled.
- Back-to-back commands: the earliest next acceptance is the IDLE cycle after DONE.

Decomposition:
- Package shreg_seq_pkg holds:
  - op enum: OP_LOAD=2'b00, OP_SHL=2'b01, OP_SHR=2'b10, OP_ROT=2'b11
  - state enum: IDLE, EXEC, DONE
  - arg field index constants: CNT_LSB=0, CNT_MSB=3, DIR_BIT=4, FILL_BIT=7
- One sub-module is natural: shreg_seq_cnt, a loadable CW-bit down-counter with clamp-to-W and an is_one flag.
- FSM and output decode stay in the top module.

Test Plan:
- Bench instantiates shreg_seq driving z61 with a shared clk.
- LOAD: cmd_op=00, cmd_arg=8'hA5 accepted -> l=r=1 for exactly 1 cycle; q=8'hA5 after the next edge; done pulses once; cmd_ready back 1 cycle later.
- SHL: from q=A5, cmd_op=01, cmd_arg=8'h83 (count 3, fill 1) -> r=1, l=0 for 3 cycles; q=8'h2F; busy high 3 cycles; single done pulse.
- SHR: from q=2F, cmd_op=10, cmd_arg=8'h02 (count 2, fill 0) -> l=1 for 2 cycles; q=8'h0B.
- ROT: from q=0B, cmd_op=11, cmd_arg=8'h14 (right, count 4) -> q=8'hB0. Then cmd_arg=8'h0C (left, count 12, clamped to 8) -> r=1 for exactly 8 cycles; q=8'hB0 unchanged.
- Count 0: cmd_op=01, cmd_arg=8'h00 -> l=r=0 throughout; done in the cycle after acceptance; q unchanged. cmd_valid held high during busy -> no second acceptance until cmd_ready=1.
- Reset mid-operation: SHL count 8, fill 0 from q=FF; assert rst after 2 shifts -> l=r=0, busy=0, done=0 immediately (asynchronously); q stays 8'hFC. After release, cmd_ready=1 and a new LOAD 8'h3C completes normally.

Source files
------------

// File: rtl/shreg_seq_pkg.sv
// Shared types and constants for the shift-register command sequencer.
// Holds the op and state encodings plus the cmd_arg field positions.
package shreg_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_ROT  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int CNT_LSB  = 0;
    localparam int CNT_MSB  = 3;
    localparam int DIR_BIT  = 4;
    localparam int FILL_BIT = 7;

    // Returns {l, r} for the downstream register; ROT borrows the SHL/SHR code.
    function automatic logic [1:0] lr_encode(input op_e op, input logic dir);
        logic [1:0] lr;
        case (op)
            OP_LOAD: lr = 2'b11;
            OP_SHL:  lr = 2'b01;
            OP_SHR:  lr = 2'b10;
            OP_ROT:  lr = dir ? 2'b10 : 2'b01;
            default: lr = 2'b00;
        endcase
        return lr;
    endfunction

endpackage

// File: rtl/shreg_seq_cnt.sv
// Loadable down-counter for the sequencer: loads a 4-bit count clamped to W,
// decrements while enabled and flags the last step with is_one_o.
module shreg_seq_cnt #(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       dec_i,
    input  logic [3:0] val_i,
    output logic       is_one_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    function automatic logic [CW-1:0] clamp(input logic [3:0] v);
        if (int'(v) > W) return CW'(W);
        return CW'(v);
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = clamp(val_i);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one_o = (cnt_q == CW'(1));

endmodule

// File: rtl/shreg_seq.sv
// Command sequencer for the 8-bit universal shift register: turns one
// LOAD/SHL/SHR/ROT command into per-cycle l/r/d/i drive and a done pulse.
module shreg_seq
    import shreg_seq_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_arg,
    input  logic [W-1:0] q,
    output logic         l,
    output logic         r,
    output logic [W-1:0] d,
    output logic         i,
    output logic         busy,
    output logic         done
);

    state_e       state_q;
    op_e          op_q;
    logic         fill_q;
    logic         dir_q;
    logic [W-1:0] d_q;
    logic         l_q;
    logic         r_q;
    logic         busy_q;
    logic         done_q;
    logic         ready_q;

    logic         accept;
    op_e          op_in;
    logic [3:0]   cnt_field;
    logic [3:0]   cnt_load_val;
    logic         cnt_is_one;
    logic [1:0]   lr_next;
    logic         unused_q;

    assign op_in        = op_e'(cmd_op);
    assign accept       = cmd_valid & ready_q;
    assign cnt_field    = cmd_arg[CNT_MSB:CNT_LSB];
    assign cnt_load_val = (op_in == OP_LOAD) ? 4'd1 : cnt_field;
    assign lr_next      = lr_encode(op_in, cmd_arg[DIR_BIT]);
    assign unused_q     = ^q[W-2:1];

    shreg_seq_cnt #(
        .W  (W),
        .CW (CW)
    ) u_cnt (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (accept),
        .dec_i    (state_q == EXEC),
        .val_i    (cnt_load_val),
        .is_one_o (cnt_is_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            fill_q  <= 1'b0;
            dir_q   <= 1'b0;
            d_q     <= '0;
            l_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_in;
                        fill_q  <= cmd_arg[FILL_BIT];
                        dir_q   <= cmd_arg[DIR_BIT];
                        ready_q <= 1'b0;
                        if (op_in == OP_LOAD) begin
                            d_q <= cmd_arg;
                        end
                        // A zero count skips EXEC entirely so the register never moves.
                        if ((op_in != OP_LOAD) && (cnt_field == 4'd0)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= EXEC;
                            busy_q  <= 1'b1;
                            l_q     <= lr_next[1];
                            r_q     <= lr_next[0];
                        end
                    end
                end
                EXEC: begin
                    if (cnt_is_one) begin
                        state_q <= DONE;
                        l_q     <= 1'b0;
                        r_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    l_q     <= 1'b0;
                    r_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Rotate feeds back the same-cycle q so the wrapped bit lands on this edge.
    always_comb begin
        i = 1'b0;
        if (state_q == EXEC) begin
            case (op_q)
                OP_SHL, OP_SHR: i = fill_q;
                OP_ROT:         i = dir_q ? q[0] : q[W-1];
                default:        i = 1'b0;
            endcase
        end
    end

    assign l         = l_q;
    assign r         = r_q;
    assign d         = d_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = ready_q;

endmodule

// File: tb/tb_shreg_seq.sv
// Directed bench: shreg_seq driving a behavioural model of the z61
// universal shift register on a shared clock.
module tb_shreg_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic [7:0] q_reg;
    logic       l, r, i, busy, done;
    logic [7:0] d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shreg_seq #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .q         (q_reg),
        .l         (l),
        .r         (r),
        .d         (d),
        .i         (i),
        .busy      (busy),
        .done      (done)
    );

    // z61 model: 00 hold, 01 shift left (bit0 <- i), 10 shift right (bit7 <- i), 11 load d.
    always_ff @(posedge clk) begin
        case ({l, r})
            2'b01:   q_reg <= {q_reg[6:0], i};
            2'b10:   q_reg <= {i, q_reg[7:1]};
            2'b11:   q_reg <= d;
            default: q_reg <= q_reg;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one command and observes every cycle from acceptance until cmd_ready returns.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg,
                           output int n_l, output int n_r, output int n_lr,
                           output int n_busy, output int n_done,
                           output int done_at, output int ready_at, output logic i0);
        n_l = 0; n_r = 0; n_lr = 0; n_busy = 0; n_done = 0;
        done_at = -1; ready_at = -1; i0 = 1'bx;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 0) i0 = i;
            if (l && r) n_lr++;
            else if (r) n_r++;
            else if (l) n_l++;
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            if (cmd_ready) begin
                ready_at = c;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_arg = 8'h00;
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
        checks++; if ({l, r} !== 2'b00) begin errors++; $display("FAIL reset_lr got %b exp 00", {l, r}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_d got %h exp 00", d); end
        checks++; if (i !== 1'b0) begin errors++; $display("FAIL reset_i got %b exp 0", i); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load;
        int nl, nr, nlr, nb, nd, da, ra;
        logic i0;
        run_cmd(2'b00, 8'hA5, nl, nr, nlr, nb, nd, da, ra, i0);
        checks++; if (nlr !== 1) begin errors++; $display("FAIL load_lr_cycles got %0d exp 1", nlr); end
        checks++; if (nl + nr !== 0) begin errors++; $display("FAIL load_shift_cycles got %0d exp 0", nl + nr); end
        checks++; if (nb !== 1) begin errors++; $display("FAIL load_busy got %0d exp 1", nb); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL load_done_pulses got %0d exp 1", nd); end
        checks++; if (da !== 1) begin errors++; $display("FAIL load_done_at got %0d exp 1", da); end
        checks++; if (ra !== 2) begin errors++; $display("FAIL load_ready_at got %0d exp 2", ra); end
        checks++; if (q_reg !== 8'hA5) begin errors++; $display("FAIL load_q got %h exp a5", q_reg); end
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL load_d got %h exp a5", d); end
    endtask

    task automatic test_shl;
        int nl, nr, nlr, nb, nd, da, ra;
        logic i0;
        run_cmd(2'b01, 8'h83, nl, nr, nlr, nb, nd, da, ra, i0);
        checks++; if (nr !== 3 || nl !== 0 || nlr !== 0) begin errors++; $display("FAIL shl_cycles got r=%0d l=%0d lr=%0d exp r=3 l=0 lr=0", nr, nl, nlr); end
        checks++; if (nb !== 3) begin errors++; $display("FAIL shl_busy got %0d exp 3", nb); end
        checks++; if (nd !== 1 || da !== 3) begin errors++; $display("FAIL shl_done got n=%0d at=%0d exp n=1 at=3", nd, da); end
        checks++; if (i0 !== 1'b1) begin errors++; $display("FAIL shl_fill_i got %b exp 1", i0); end
        checks++; if (q_reg !== 8'h2F) begin errors++; $display("FAIL shl_q got %h exp 2f", q_reg); end
    endtask

    task automatic test_shr;
        int nl, nr, nlr, nb, nd, da, ra;
        logic i0;
        run_cmd(2'b10, 8'h02, nl, nr, nlr, nb, nd, da, ra, i0);
        checks++; if (nl !== 2 || nr !== 0) begin errors++; $display("FAIL shr_cycles got l=%0d r=%0d exp l=2 r=0", nl, nr); end
        checks++; if (ra !== 3) begin errors++; $display("FAIL shr_ready_at got %0d exp 3", ra); end
        checks++; if (q_reg !== 8'h0B) begin errors++; $display("FAIL shr_q got %h exp 0b", q_reg); end
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL shr_d_hold got %h exp a5", d); end
    endtask

    task automatic test_rot;
        int nl, nr, nlr, nb, nd, da, ra;
        logic i0;
        run_cmd(2'b11, 8'h14, nl, nr, nlr, nb, nd, da, ra, i0);
        checks++; if (nl !== 4 || nr !== 0) begin errors++; $display("FAIL rotr_cycles got l=%0d r=%0d exp l=4 r=0", nl, nr); end
        checks++; if (i0 !== 1'b1) begin errors++; $display("FAIL rotr_i got %b exp 1", i0); end
        checks++; if (q_reg !== 8'hB0) begin errors++; $display("FAIL rotr_q got %h exp b0", q_reg); end
        run_cmd(2'b11, 8'h0C, nl, nr, nlr, nb, nd, da, ra, i0);
        checks++; if (nr !== 8 || nl !== 0) begin errors++; $display("FAIL rotl_clamp_cycles got r=%0d l=%0d exp r=8 l=0", nr, nl); end
        checks++; if (da !== 8) begin errors++; $display("FAIL rotl_done_at got %0d exp 8", da); end
        checks++; if (i0 !== 1'b1) begin errors++; $display("FAIL rotl_i got %b exp 1", i0); end
        checks++; if (q_reg !== 8'hB0) begin errors++; $display("FAIL rotl_q got %h exp b0", q_reg); end
    endtask

    task automatic test_busy_hold;
        int nb = 0, nd = 0, nlr = 0, ra = -1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_arg   = 8'h02;
        tick();
        cmd_op  = 2'b00;
        cmd_arg = 8'h81;
        for (int c = 0; c < 40; c++) begin
            if (busy) nb++;
            if (done) nd++;
            if (l && r) nlr++;
            if (cmd_ready) begin
                ra = c;
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
        checks++; if (nb !== 2) begin errors++; $display("FAIL hold_busy got %0d exp 2", nb); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL hold_done got %0d exp 1", nd); end
        checks++; if (nlr !== 0) begin errors++; $display("FAIL hold_no_load got %0d exp 0", nlr); end
        checks++; if (ra !== 3) begin errors++; $display("FAIL hold_ready_at got %0d exp 3", ra); end
        checks++; if (q_reg !== 8'hC0) begin errors++; $display("FAIL hold_q got %h exp c0", q_reg); end
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL hold_d got %h exp a5", d); end
    endtask

    task automatic test_count0;
        int nl, nr, nlr, nb, nd, da, ra;
        logic i0;
        run_cmd(2'b01, 8'h00, nl, nr, nlr, nb, nd, da, ra, i0);
        checks++; if (nl + nr + nlr !== 0) begin errors++; $display("FAIL cnt0_activity got %0d exp 0", nl + nr + nlr); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL cnt0_busy got %0d exp 0", nb); end
        checks++; if (da !== 0 || nd !== 1) begin errors++; $display("FAIL cnt0_done got at=%0d n=%0d exp at=0 n=1", da, nd); end
        checks++; if (ra !== 1) begin errors++; $display("FAIL cnt0_ready_at got %0d exp 1", ra); end
        checks++; if (q_reg !== 8'hC0) begin errors++; $display("FAIL cnt0_q got %h exp c0", q_reg); end
    endtask

    task automatic test_reset_mid;
        int nl, nr, nlr, nb, nd, da, ra;
        logic i0;
        run_cmd(2'b00, 8'hFF, nl, nr, nlr, nb, nd, da, ra, i0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_arg   = 8'h08;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({l, r} !== 2'b00) begin errors++; $display("FAIL arst_lr got %b exp 00", {l, r}); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_busy_done got %b%b exp 00", busy, done); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", cmd_ready); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL arst_d got %h exp 00", d); end
        tick();
        checks++; if (q_reg !== 8'hFC) begin errors++; $display("FAIL arst_q got %h exp fc", q_reg); end
        rst = 1'b0;
        tick();
        run_cmd(2'b00, 8'h3C, nl, nr, nlr, nb, nd, da, ra, i0);
        checks++; if (nlr !== 1 || nd !== 1 || ra !== 2) begin errors++; $display("FAIL post_rst_load got lr=%0d done=%0d ready_at=%0d exp 1 1 2", nlr, nd, ra); end
        checks++; if (q_reg !== 8'h3C) begin errors++; $display("FAIL post_rst_q got %h exp 3c", q_reg); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_shl();
        test_shr();
        test_rot();
        test_busy_hold();
        test_count0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
